// File: rtl/qeciphy_tx_scheduler.sv
// Round-robin scheduler sharing the QECIPHY TX AXI-Stream among NUM_REQ requesters.
// Grants bounded bursts, registers the outgoing beat and flushes it when the link drops.
module qeciphy_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16
) (
    input  logic                      ACLK,
    input  logic                      ARST,
    input  logic                      LINK_READY,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_TDATA,
    input  logic [NUM_REQ-1:0]        REQ_TVALID,
    output logic [NUM_REQ-1:0]        REQ_TREADY,
    output logic [DATA_W-1:0]         TX_TDATA,
    output logic                      TX_TVALID,
    input  logic                      TX_TREADY,
    output logic [NUM_REQ-1:0]        GRANT,
    output logic [15:0]               FLUSH_CNT
);

    localparam int PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_DOWN  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [1:0]         state;
    logic [NUM_REQ-1:0] grant_q;
    logic [PW-1:0]      ptr;
    logic [7:0]         bcnt;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic [15:0]        flush_cnt;

    logic               slot_free;
    logic               in_burst;
    logic               gnt_valid;
    logic               accept;
    logic               burst_full;
    logic               found;
    logic [PW-1:0]      pick;
    logic [DATA_W-1:0]  sel_data;

    // Output slot can take a new beat when empty or draining this cycle.
    assign slot_free  = !tx_valid || TX_TREADY;
    // Link loss kills the handshake in the same cycle it is seen.
    assign in_burst   = (state == S_BURST) && LINK_READY;
    assign gnt_valid  = |(REQ_TVALID & grant_q);
    assign accept     = in_burst && slot_free && gnt_valid;
    assign burst_full = ({1'b0, bcnt} + 9'd1) == 9'(MAX_BURST);

    // Ready never looks at REQ_TVALID, so requesters may wait on it safely.
    assign REQ_TREADY = grant_q & {NUM_REQ{in_burst && slot_free}};
    assign GRANT      = LINK_READY ? grant_q : '0;
    assign TX_TDATA   = tx_data;
    assign TX_TVALID  = tx_valid;
    assign FLUSH_CNT  = flush_cnt;

    // Round-robin pick: first valid above ptr, then wrap to indices 0..ptr.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && REQ_TVALID[i] && (i > int'(ptr))) begin
                found = 1'b1;
                pick  = PW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && REQ_TVALID[i] && (i <= int'(ptr))) begin
                found = 1'b1;
                pick  = PW'(i);
            end
        end
    end

    // Data mux driven by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) sel_data = REQ_TDATA[i*DATA_W +: DATA_W];
        end
    end

    // Link/arbitration state machine: DOWN -> IDLE -> BURST -> IDLE ...
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state   <= S_DOWN;
            grant_q <= '0;
            ptr     <= PW'(NUM_REQ - 1);
            bcnt    <= '0;
        end else if (!LINK_READY) begin
            state   <= S_DOWN;
            grant_q <= '0;
            bcnt    <= '0;
        end else begin
            case (state)
                S_DOWN: state <= S_IDLE;
                S_IDLE: begin
                    if (found) begin
                        grant_q <= NUM_REQ'(1) << pick;
                        ptr     <= pick;
                        bcnt    <= '0;
                        state   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (accept) bcnt <= bcnt + 8'd1;
                    // Full burst or a grantee with nothing to send ends the grant.
                    if ((accept && burst_full) || (slot_free && !gnt_valid)) begin
                        grant_q <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= S_DOWN;
                end
            endcase
        end
    end

    // Output beat register: hold while stalled, load on accept, drop on link loss.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            flush_cnt <= '0;
        end else if (!LINK_READY) begin
            // A beat already taken by the PHY this cycle is not a loss.
            if (tx_valid && !TX_TREADY && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
            tx_valid <= 1'b0;
        end else if (accept) begin
            tx_data  <= sel_data;
            tx_valid <= 1'b1;
        end else if (TX_TREADY) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qeciphy_tx_scheduler.sv
// Directed bench for qeciphy_tx_scheduler: link gating, round-robin bursts,
// stalls, link-loss flush, reset mid-burst and a short random soak.
module tb_qeciphy_tx_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 16;

    logic                      clk;
    logic                      arst;
    logic                      link_ready;
    logic [NUM_REQ*DATA_W-1:0] req_tdata;
    logic [NUM_REQ-1:0]        req_tvalid;
    logic [NUM_REQ-1:0]        req_tready;
    logic [DATA_W-1:0]         tx_tdata;
    logic                      tx_tvalid;
    logic                      tx_tready;
    logic [NUM_REQ-1:0]        grant;
    logic [15:0]               flush_cnt;

    int checks = 0;
    int errors = 0;

    // Requester source model: each stream sends {index, sequence} beats.
    int                 cnt [NUM_REQ];
    int                 lim [NUM_REQ];
    logic [NUM_REQ-1:0] take;

    qeciphy_tx_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .ACLK      (clk),
        .ARST      (arst),
        .LINK_READY(link_ready),
        .REQ_TDATA (req_tdata),
        .REQ_TVALID(req_tvalid),
        .REQ_TREADY(req_tready),
        .TX_TDATA  (tx_tdata),
        .TX_TVALID (tx_tvalid),
        .TX_TREADY (tx_tready),
        .GRANT     (grant),
        .FLUSH_CNT (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic src_clear(input int l);
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] = 0;
            lim[i] = l;
        end
        take       = '0;
        req_tvalid = '0;
        req_tdata  = '0;
    endtask

    // Retire last cycle's handshakes, then present the next beat per stream.
    task automatic src_update(input logic [NUM_REQ-1:0] want);
        logic hold;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take[i]) cnt[i]++;
            hold          = req_tvalid[i] && !take[i];
            req_tvalid[i] = hold || (want[i] && (cnt[i] < lim[i]));
            req_tdata[i*DATA_W +: DATA_W] = {32'(i), 32'(cnt[i])};
        end
        take = '0;
    endtask

    task automatic apply_reset(input logic link);
        arst = 1'b1;
        src_clear(0);
        tx_tready  = 1'b0;
        link_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst       = 1'b0;
        link_ready = link;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (req_tready !== '0) begin errors++; $display("FAIL reset_req_tready: got %b want 0000", req_tready); end
        checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tx_tvalid: got %b want 0", tx_tvalid); end
        checks++; if (tx_tdata !== '0) begin errors++; $display("FAIL reset_tx_tdata: got %h want 0", tx_tdata); end
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
    endtask

    task automatic test_link_gate;
        arst       = 1'b0;
        link_ready = 1'b0;
        req_tvalid = '1;
        tx_tready  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (req_tready !== '0 || tx_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL link_gate cyc %0d: got ready %b valid %b want 0000/0", c, req_tready, tx_tvalid);
            end
        end
        link_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL link_up_idle_grant: got %b want 0000", grant); end
        @(negedge clk);
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL link_up_first_grant: got %b want 0001", grant); end
    endtask

    task automatic test_round_robin;
        logic [NUM_REQ-1:0] prev;
        logic [NUM_REQ-1:0] gseq[$];
        logic [DATA_W-1:0]  exp;
        int got;
        int gaps;
        src_clear(1000);
        got  = 0;
        gaps = 0;
        prev = grant;
        for (int c = 0; c < 300 && got < 80; c++) begin
            src_update(4'b1111);
            #1;
            if (tx_tvalid && tx_tready) begin
                exp = {32'((got / 16) % 4), 32'((got / 64) * 16 + got % 16)};
                checks++;
                if (tx_tdata !== exp) begin
                    errors++;
                    $display("FAIL rr_beat %0d: got %h want %h", got, tx_tdata, exp);
                end
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            if (grant != '0 && grant != prev) begin
                gseq.push_back(grant);
                prev = grant;
            end
            take = req_tvalid & req_tready;
            @(negedge clk);
        end
        checks++; if (got != 80) begin errors++; $display("FAIL rr_beat_count: got %0d want 80", got); end
        checks++; if (gaps != 4) begin errors++; $display("FAIL rr_bubbles: got %0d want 4", gaps); end
        checks++;
        if (gseq.size() != 4 || gseq[0] !== 4'b0010 || gseq[1] !== 4'b0100 ||
            gseq[2] !== 4'b1000 || gseq[3] !== 4'b0001) begin
            errors++;
            $display("FAIL rr_grant_order: got %0d grants %p want 0010,0100,1000,0001", gseq.size(), gseq);
        end
    endtask

    task automatic test_stall;
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] exp;
        int got;
        apply_reset(1'b1);
        src_clear(5);
        got        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            tx_tready = (c % 2) == 1;
            src_update(4'b0100);
            #1;
            if (prev_stall) begin
                checks++;
                if (!tx_tvalid || tx_tdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got %b/%h want 1/%h", tx_tvalid, tx_tdata, prev_data);
                end
            end
            if (tx_tvalid && tx_tready) begin
                exp = {32'd2, 32'(got)};
                checks++;
                if (tx_tdata !== exp) begin
                    errors++;
                    $display("FAIL stall_beat %0d: got %h want %h", got, tx_tdata, exp);
                end
                got++;
            end
            prev_stall = tx_tvalid && !tx_tready;
            prev_data  = tx_tdata;
            take = req_tvalid & req_tready;
            @(negedge clk);
        end
        checks++; if (got != 5) begin errors++; $display("FAIL stall_beat_count: got %0d want 5", got); end
        tx_tready = 1'b1;
        repeat (3) begin
            src_update(4'b0000);
            take = req_tvalid & req_tready;
            @(negedge clk);
        end
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_grant_end: got %b want 0000", grant); end
        checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL stall_no_extra: got %b want 0", tx_tvalid); end
        checks++; if (cnt[2] != 5) begin errors++; $display("FAIL stall_handshakes: got %0d want 5", cnt[2]); end
    endtask

    task automatic test_link_drop;
        logic ok;
        apply_reset(1'b1);
        src_clear(100);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            src_update(4'b0001);
            #1;
            if (tx_tvalid) begin
                ok = 1'b1;
                break;
            end
            take = req_tvalid & req_tready;
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL drop_setup: got tx_tvalid 0 want 1"); end
        // Stalled beat in the register when the link goes away.
        link_ready = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_grant_same_cycle: got %b want 0000", grant); end
        @(negedge clk);
        #1;
        checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL drop_tx_tvalid: got %b want 0", tx_tvalid); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL drop_flush_cnt: got %0d want 1", flush_cnt); end
        // Two-cycle grant latency shows the FSM went through DOWN.
        link_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_down_state: got %b want 0000", grant); end
        @(negedge clk);
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL drop_regrant: got %b want 0001", grant); end
        // Beat handed over in the drop cycle is not counted as flushed.
        tx_tready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (tx_tvalid !== 1'b1) begin errors++; $display("FAIL drop2_setup: got %b want 1", tx_tvalid); end
        link_ready = 1'b0;
        #1;
        checks++; if (req_tready !== 4'b0000) begin errors++; $display("FAIL drop2_req_tready: got %b want 0000", req_tready); end
        @(negedge clk);
        #1;
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL drop2_flush_cnt: got %0d want 1", flush_cnt); end
        checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL drop2_tx_tvalid: got %b want 0", tx_tvalid); end
        req_tvalid = '0;
    endtask

    task automatic test_arst_mid_burst;
        logic [DATA_W-1:0] exp;
        logic ok;
        int got;
        // Link is down with FLUSH_CNT=1 from the previous scenario.
        src_clear(100);
        link_ready = 1'b1;
        tx_tready  = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            src_update(4'b0010);
            #1;
            if (tx_tvalid && tx_tready) begin
                exp = {32'd1, 32'(got)};
                checks++;
                if (tx_tdata !== exp) begin
                    errors++;
                    $display("FAIL arst_beat %0d: got %h want %h", got, tx_tdata, exp);
                end
                got++;
            end
            if (got == 7) break;
            take = req_tvalid & req_tready;
            @(negedge clk);
        end
        checks++; if (got != 7) begin errors++; $display("FAIL arst_setup: got %0d beats want 7", got); end
        arst = 1'b1;
        #1;
        checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL arst_tx_tvalid: got %b want 0", tx_tvalid); end
        checks++; if (tx_tdata !== '0) begin errors++; $display("FAIL arst_tx_tdata: got %h want 0", tx_tdata); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL arst_grant: got %b want 0000", grant); end
        checks++; if (req_tready !== 4'b0000) begin errors++; $display("FAIL arst_req_tready: got %b want 0000", req_tready); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL arst_flush_cnt: got %0d want 0", flush_cnt); end
        @(negedge clk);
        arst = 1'b0;
        src_clear(100);
        req_tvalid = '1;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || grant !== 4'b0001) begin
            errors++;
            $display("FAIL arst_restart_grant: got %b want 0001", grant);
        end
    endtask

    task automatic test_random;
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic [NUM_REQ-1:0] want;
        int exp_seq [NUM_REQ];
        int total;
        int r;
        int s;
        apply_reset(1'b1);
        src_clear(48);
        for (int i = 0; i < NUM_REQ; i++) exp_seq[i] = 0;
        total      = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 6000 && total < 48 * NUM_REQ; c++) begin
            tx_tready = ($urandom_range(0, 3) != 0);
            want      = NUM_REQ'($urandom);
            src_update(want);
            #1;
            if (prev_stall) begin
                checks++;
                if (!tx_tvalid || tx_tdata !== prev_data) begin
                    errors++;
                    $display("FAIL rand_hold: got %b/%h want 1/%h", tx_tvalid, tx_tdata, prev_data);
                end
            end
            if (tx_tvalid && tx_tready) begin
                r = int'(tx_tdata[63:32]);
                s = int'(tx_tdata[31:0]);
                checks++;
                if (r >= NUM_REQ || s != exp_seq[r]) begin
                    errors++;
                    $display("FAIL rand_order: got req %0d seq %0d", r, s);
                end else begin
                    exp_seq[r]++;
                end
                total++;
            end
            prev_stall = tx_tvalid && !tx_tready;
            prev_data  = tx_tdata;
            take = req_tvalid & req_tready;
            @(negedge clk);
        end
        checks++;
        if (total != 48 * NUM_REQ) begin
            errors++;
            $display("FAIL rand_total: got %0d want %0d", total, 48 * NUM_REQ);
        end
        checks++;
        if (exp_seq[0] != 48 || exp_seq[1] != 48 || exp_seq[2] != 48 || exp_seq[3] != 48) begin
            errors++;
            $display("FAIL rand_per_req: got %0d %0d %0d %0d want 48 each",
                     exp_seq[0], exp_seq[1], exp_seq[2], exp_seq[3]);
        end
    endtask

    initial begin
        arst       = 1'b1;
        link_ready = 1'b0;
        req_tvalid = '0;
        req_tdata  = '0;
        tx_tready  = 1'b0;
        take       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] = 0;
            lim[i] = 0;
        end
        test_reset;
        test_link_gate;
        test_round_robin;
        test_stall;
        test_link_drop;
        test_arst_mid_burst;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
